// File: rtl/descrambler.sv
`default_nettype none
// ============================================================================
// Module   : descrambler
// Purpose  : CCSDS PN descrambler, 8 bits per accepted byte, 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module descrambler #(
    parameter logic [7:0] SEED = 8'hFF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cvcdu_new,
    input  logic       data_valid_in,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out,
    output logic       data_valid_out
);

    localparam int c_steps = 8;

    logic [7:0] r_lfsr;
    logic [7:0] r_byte_out;
    logic       r_data_valid_out;

    logic [7:0] w_lfsr_base;
    logic [7:0] w_lfsr_adv;
    logic [7:0] w_pn_byte;
    logic [7:0] w_s;

    // A new CVCDU restarts the sequence even for the byte accepted in that cycle.
    assign w_lfsr_base = cvcdu_new ? SEED : r_lfsr;

    // Eight LFSR steps unrolled; the first output bit lands in bit 7.
    always_comb begin
        w_pn_byte  = '0;
        w_s        = w_lfsr_base;
        for (int i = 0; i < c_steps; i++) begin
            w_pn_byte[c_steps-1-i] = w_s[0];
            w_s = {w_s[0] ^ w_s[3] ^ w_s[5] ^ w_s[7], w_s[7:1]};
        end
        w_lfsr_adv = w_s;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_lfsr           <= SEED;
            r_byte_out       <= 8'h00;
            r_data_valid_out <= 1'b0;
        end else begin
            r_data_valid_out <= data_valid_in;
            if (data_valid_in) begin
                r_byte_out <= byte_in ^ w_pn_byte;
                r_lfsr     <= w_lfsr_adv;
            end else if (cvcdu_new) begin
                r_lfsr     <= SEED;
            end
        end
    end

    assign byte_out       = r_byte_out;
    assign data_valid_out = r_data_valid_out;

endmodule
`default_nettype wire

// File: tb/tb_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_descrambler
// Purpose  : Directed self-checking bench for the descrambler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_descrambler;

    logic       clk;
    logic       rst_n;
    logic       cvcdu_new;
    logic       data_valid_in;
    logic [7:0] byte_in;
    logic [7:0] byte_out;
    logic       data_valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_tab [0:7];
    logic [7:0] m_lfsr;
    logic [7:0] m_pn;
    logic [7:0] held;

    descrambler #(.SEED(8'hFF)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .cvcdu_new     (cvcdu_new),
        .data_valid_in (data_valid_in),
        .byte_in       (byte_in),
        .byte_out      (byte_out),
        .data_valid_out(data_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, return 1 ns after the rising edge.
    task automatic step(input logic dv, input logic [7:0] b, input logic cv);
        @(negedge clk);
        data_valid_in = dv;
        byte_in       = b;
        cvcdu_new     = cv;
        @(posedge clk);
        #1;
        @(negedge clk);
        data_valid_in = 1'b0;
        cvcdu_new     = 1'b0;
        byte_in       = 8'h00;
        #0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bench-side PN model: shift register written as the CCSDS taps 8,7,5,3.
    task automatic model_byte(output logic [7:0] pn);
        logic fb;
        pn = '0;
        for (int k = 0; k < 8; k++) begin
            pn = {pn[6:0], m_lfsr[0]};
            fb = m_lfsr[0] ^ m_lfsr[3] ^ m_lfsr[5] ^ m_lfsr[7];
            m_lfsr = m_lfsr >> 1;
            m_lfsr[7] = fb;
        end
    endtask

    initial begin
        ref_tab[0] = 8'hFF; ref_tab[1] = 8'h48; ref_tab[2] = 8'h0E; ref_tab[3] = 8'hC0;
        ref_tab[4] = 8'h9A; ref_tab[5] = 8'h0D; ref_tab[6] = 8'h70; ref_tab[7] = 8'hBC;

        rst_n = 1'b0; cvcdu_new = 1'b0; data_valid_in = 1'b0; byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset byte_out", {24'h0, byte_out}, 32'h00);
        check("reset dv", {31'h0, data_valid_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four back-to-back zero bytes, checked one cycle after each input.
        @(negedge clk);
        data_valid_in = 1'b1; byte_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("b2b byte", {24'h0, byte_out}, {24'h0, ref_tab[i]});
            check("b2b dv", {31'h0, data_valid_out}, 32'h1);
        end
        @(negedge clk);
        data_valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("b2b dv drop", {31'h0, data_valid_out}, 32'h0);
        check("b2b hold", {24'h0, byte_out}, 32'hC0);

        // All-ones input inverts the PN sequence.
        do_reset();
        step(1'b1, 8'hFF, 1'b0);
        check("ff byte0", {24'h0, byte_out}, 32'h00);
        step(1'b1, 8'hFF, 1'b0);
        check("ff byte1", {24'h0, byte_out}, 32'hB7);

        // Sparse stream across the 255-byte period.
        do_reset();
        m_lfsr = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'h00, 1'b0);
            model_byte(m_pn);
            if (i < 8)    check("sparse table", {24'h0, byte_out}, {24'h0, ref_tab[i]});
            if (i == 255) check("period wrap", {24'h0, byte_out}, 32'hFF);
            check("sparse byte", {24'h0, byte_out}, {24'h0, m_pn});
            check("sparse dv", {31'h0, data_valid_out}, 32'h1);
            held = byte_out;
            for (int g = 0; g < 15; g++) begin
                @(posedge clk);
                #1;
                if (g == 0 || g == 14) begin
                    check("gap dv", {31'h0, data_valid_out}, 32'h0);
                    check("gap hold", {24'h0, byte_out}, {24'h0, held});
                end
            end
        end

        // cvcdu_new alone, then coincident with a byte.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
        check("pre cvcdu", {24'h0, byte_out}, 32'h0E);
        step(1'b0, 8'h00, 1'b1);
        check("cvcdu idle dv", {31'h0, data_valid_out}, 32'h0);
        step(1'b1, 8'h00, 1'b0);
        check("cvcdu alone", {24'h0, byte_out}, 32'hFF);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        check("cvcdu coinc", {24'h0, byte_out}, 32'hFF);
        step(1'b1, 8'h00, 1'b0);
        check("cvcdu next", {24'h0, byte_out}, 32'h48);

        // Asynchronous mid-stream reset while an output is valid.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        data_valid_in = 1'b1; byte_in = 8'h00;
        @(posedge clk);
        #1;
        check("pre-rst dv", {31'h0, data_valid_out}, 32'h1);
        check("pre-rst byte", {24'h0, byte_out}, 32'h9A);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst byte", {24'h0, byte_out}, 32'h00);
        check("async rst dv", {31'h0, data_valid_out}, 32'h0);
        @(negedge clk);
        data_valid_in = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 8'h00, 1'b0);
        check("post-rst byte", {24'h0, byte_out}, 32'hFF);
        check("post-rst dv", {31'h0, data_valid_out}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/descrambler.md
DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 Parameter SEED, default 8'hFF: LFSR load value at reset and at each cvcdu_new.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 cvcdu_new  input  1  single-cycle pulse marking the start of a new CVCDU; restarts the PN sequence.
REQ-005 data_valid_in  input  1  byte_in qualifier; one byte accepted per cycle when high.
REQ-006 byte_in  input  8  scrambled byte, MSB = first transmitted bit.
REQ-007 byte_out  output  8  descrambled byte, registered.
REQ-008 data_valid_out  output  1  byte_out qualifier, registered, high one cycle per accepted byte.

Function
REQ-009 The PN generator SHALL be an 8-bit register s[7:0] implementing h(x)=x^8+x^7+x^5+x^3+1 (CCSDS), one step = output bit s[0], then s <= {s[0]^s[3]^s[5]^s[7], s[7:1]}.
REQ-010 The PN byte for an accepted byte SHALL be the 8 output bits of 8 consecutive steps, first bit in bit 7; all 8 steps computed combinationally within one cycle.
REQ-011 From SEED=8'hFF the PN byte sequence SHALL start FF 48 0E C0 9A 0D 70 BC and repeat with a period of 255 bytes.
REQ-012 On an accepting cycle (data_valid_in=1): byte_out <= byte_in XOR pn_byte, data_valid_out <= 1, LFSR advances 8 steps.
REQ-013 Latency SHALL be exactly one clock from byte_in sampling to byte_out/data_valid_out.
REQ-014 When data_valid_in=0: LFSR holds, data_valid_out <= 0, byte_out holds its last value.
REQ-015 Gaps in data_valid_in of any length SHALL NOT affect the PN sequence; only accepted bytes advance it.
REQ-016 cvcdu_new=1 with data_valid_in=0: LFSR <= SEED; the next accepted byte uses PN byte 0xFF.
REQ-017 cvcdu_new=1 with data_valid_in=1 in the same cycle: that byte SHALL be XORed with PN byte 0xFF (sequence from SEED) and LFSR <= SEED advanced 8 steps (next PN byte 0x48).
REQ-018 No byte counter or CVCDU length check; without cvcdu_new the sequence SHALL free-run across the 255-byte period boundary.
REQ-019 No backpressure; the block SHALL accept a byte on every cycle data_valid_in is high, including back-to-back.

Reset
REQ-020 While rst_in=0, asynchronously: byte_out=8'h00, data_valid_out=0, LFSR=SEED.
REQ-021 After rst_in deasserts, the first accepted byte SHALL use PN byte 0xFF with no cvcdu_new required.
REQ-022 Reset mid-stream SHALL discard the in-flight output (data_valid_out forced 0) and restart the sequence from SEED.

Verification
REQ-023 Assert rst_in=0 mid-cycle -> byte_out=00, data_valid_out=0 immediately, without waiting for a clock edge.
REQ-024 After reset, byte_in=00 accepted four times back-to-back -> byte_out FF, 48, 0E, C0 on consecutive cycles, each one cycle after input, data_valid_out high each cycle.
REQ-025 byte_in=00 accepted once every 16 cycles, 300 times -> data_valid_out single-cycle pulses; outputs follow REQ-011, byte 256 = FF (period wrap), byte_out stable between pulses.
REQ-026 Accept 3 bytes of 00, pulse cvcdu_new alone, accept 00 -> last output FF; repeat with cvcdu_new coincident with data_valid_in -> FF then 48 on the next accepted 00.
REQ-027 byte_in=FF after reset, two bytes -> byte_out 00, B7.
REQ-028 Reset asserted after 5 accepted bytes, then released, accept 00 -> byte_out FF.
